ext_axil_mst: RTL and testbench
===============================

// Module: ext_axil_mst
// PURPOSE
//  AXI4-Lite master bridge: converts the simple ext req/rsp memory interface (core side) into
//  AXI4-Lite read/write transactions. It is the initiator-side counterpart of axil_ext and is
//  placed between a core's load/store port and the AXI-Lite interconnect. One transaction outstanding.
// PARAMETERS
//  MEM_BASE    32'h10000000   added to ext_addr to form axi_awaddr/axi_araddr (modulo 2^ADDR_WIDTH)
//  DATA_WIDTH  32             data bus width
//  ADDR_WIDTH  32             address bus width
//  STRB_WIDTH  DATA_WIDTH/8   byte-strobe width (derived, do not override)
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst_n         in   1           asynchronous active-low reset
//  ext_rd_req    in   1           read request, accepted when ext_req_rdy=1
//  ext_wr_req    in   1           write request, accepted when ext_req_rdy=1
//  ext_addr      in   ADDR_WIDTH  byte offset from MEM_BASE
//  ext_wr_dat    in   DATA_WIDTH  write data
//  ext_wen       in   STRB_WIDTH  write byte enables -> axi_wstrb
//  ext_req_rdy   out  1           1 only in IDLE
//  ext_rrsp_dat  out  DATA_WIDTH  read data, valid with ext_rrsp_val
//  ext_rrsp_val  out  1           1-cycle pulse, read complete
//  ext_wrsp_val  out  1           1-cycle pulse, write complete
//  ext_rsp_err   out  1           valid with either rsp pulse: 1 if resp != OKAY
//  axi_awaddr/awvalid out, axi_awready in; axi_wdata/wstrb/wvalid out, axi_wready in
//  axi_bresp[1:0]/bvalid in, axi_bready out; axi_araddr/arvalid out, axi_arready in
//  axi_rdata/rresp[1:0]/rvalid in, axi_rready out   (standard AXI4-Lite master, widths per params)
// BEHAVIOUR
//  Reset: state=IDLE; all axi_*valid, axi_bready, axi_rready, ext_*_val, ext_rsp_err = 0;
//   ext_rrsp_dat, addr/data regs = 0. Reset mid-transaction aborts it; no response is issued.
//  States: IDLE, WR (AW/W phase), WR_RSP, RD_ADDR, RD_DATA.
//  IDLE: accept = (ext_wr_req|ext_rd_req). Write has priority when both are set in the same cycle;
//   the read is dropped and is not reissued internally (the requester re-presents it).
//   On write: register addr+MEM_BASE, ext_wr_dat, ext_wen; next cycle awvalid=wvalid=1 (-> WR).
//   On read: register addr+MEM_BASE; next cycle arvalid=1 (-> RD_ADDR).
//  WR: AW and W complete independently. Track aw_done/w_done. Drop each valid on its own handshake.
//   Any order of awready/wready is allowed, including the same cycle. When both are done -> WR_RSP.
//  WR_RSP: bready=1. On bvalid: ext_wrsp_val=1 next cycle, ext_rsp_err=(bresp!=2'b00) -> IDLE.
//  RD_ADDR: hold arvalid until arready -> RD_DATA.
//  RD_DATA: rready=1. On rvalid: ext_rrsp_dat<=rdata, ext_rrsp_val=1 next cycle,
//   ext_rsp_err=(rresp!=2'b00) -> IDLE.
//  Once asserted, a valid is never dropped and its payload never changes before its handshake (AXI rule).
//  All outputs are registered. Minimum latency with all readies/valids at the earliest cycle:
//   write: req@0 -> aw/wvalid@1 -> bready@2 -> wrsp_val@3.
//   read:  req@0 -> arvalid@1 -> rready@2 -> rrsp_val@3.
//  ext_req_rdy returns to 1 in the same cycle as the rsp pulse. A back-to-back request may be
//   accepted in that cycle.
//  Requests presented while ext_req_rdy=0 are ignored. Address add wraps modulo 2^ADDR_WIDTH.
//  No timeout: a slave that never responds holds the FSM (documented limitation).
// STRUCTURE
//  axil_pkg: resp_e {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}; mst_state_e enum.
//  Single module, one FSM. No sub-module: a single outstanding transaction shares
//   the state and address register between the read and write paths.
// TESTING
//  1 Write ext_addr=0x4, dat=0xDEADBEEF, wen=0xF; awready/wready/bvalid immediate
//    -> awaddr=0x10000004, wstrb=0xF, wrsp_val@3, err=0.
//  2 Read ext_addr=0x8; arready after 3 cycles, rdata=0x12345678 -> araddr=0x10000008,
//    rrsp_dat=0x12345678, err=0.
//  3 Write with wready 2 cycles before awready, then reversed -> each valid drops on its
//    own handshake; exactly one wrsp_val per write.
//  4 rd_req=wr_req=1 in the same cycle -> only the write is issued; arvalid stays 0.
//  5 bresp=SLVERR, then rresp=DECERR -> ext_rsp_err=1 with the matching rsp pulse.
//  6 rst_n low while in WR_RSP -> all valids/readies are 0 immediately; no wrsp_val;
//    after reset release, ext_req_rdy=1.

Source files
------------

// File: rtl/ext_axil_mst_pkg.sv
// Shared types for the ext -> AXI4-Lite master bridge: AXI response codes,
// master FSM states and the default memory window base.
package ext_axil_mst_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RSP,
    ST_RD_ADDR,
    ST_RD_DATA
  } mst_state_e;

  localparam logic [31:0] DEFAULT_MEM_BASE = 32'h1000_0000;

  // EXOKAY is treated as an error too: this master never issues exclusive accesses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/ext_axil_mst_if.sv
// AXI4-Lite bus bundle shared by the bridge (master modport) and whatever
// slave or interconnect port sits on the other side (slave modport).
interface ext_axil_mst_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic                  axi_awvalid;
  logic                  axi_awready;

  logic [DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_WIDTH-1:0] axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;

  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;

  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;

  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, input  axi_awready,
    output axi_wdata,  axi_wstrb,   axi_wvalid, input axi_wready,
    input  axi_bresp,  axi_bvalid,  output axi_bready,
    output axi_araddr, axi_arvalid, input  axi_arready,
    input  axi_rdata,  axi_rresp,   axi_rvalid, output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, output axi_awready,
    input  axi_wdata,  axi_wstrb,   axi_wvalid, output axi_wready,
    output axi_bresp,  axi_bvalid,  input  axi_bready,
    input  axi_araddr, axi_arvalid, output axi_arready,
    output axi_rdata,  axi_rresp,   axi_rvalid, input  axi_rready
  );

endinterface

// File: rtl/ext_axil_mst.sv
// AXI4-Lite master bridge: turns single-outstanding ext read/write requests from a
// core load/store port into AXI4-Lite transactions. Every output comes straight from a flop.
module ext_axil_mst
  import ext_axil_mst_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_BASE   = ADDR_WIDTH'(DEFAULT_MEM_BASE),
  localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  i_ext_rd_req,
  input  logic                  i_ext_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_ext_addr,
  input  logic [DATA_WIDTH-1:0] i_ext_wr_dat,
  input  logic [STRB_WIDTH-1:0] i_ext_wen,
  output logic                  o_ext_req_rdy,
  output logic [DATA_WIDTH-1:0] o_ext_rrsp_dat,
  output logic                  o_ext_rrsp_val,
  output logic                  o_ext_wrsp_val,
  output logic                  o_ext_rsp_err,

  ext_axil_mst_if.master        m_axi
);

  mst_state_e            r_state,    w_state;
  logic [ADDR_WIDTH-1:0] r_addr,     w_addr;
  logic [DATA_WIDTH-1:0] r_wdata,    w_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb,    w_wstrb;
  logic                  r_awvalid,  w_awvalid;
  logic                  r_wvalid,   w_wvalid;
  logic                  r_bready,   w_bready;
  logic                  r_arvalid,  w_arvalid;
  logic                  r_rready,   w_rready;
  logic [DATA_WIDTH-1:0] r_rrsp_dat, w_rrsp_dat;
  logic                  r_rrsp_val, w_rrsp_val;
  logic                  r_wrsp_val, w_wrsp_val;
  logic                  r_rsp_err,  w_rsp_err;
  logic                  r_req_rdy,  w_req_rdy;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_aw_hs = r_awvalid & m_axi.axi_awready;
  assign w_w_hs  = r_wvalid  & m_axi.axi_wready;
  assign w_b_hs  = r_bready  & m_axi.axi_bvalid;
  assign w_ar_hs = r_arvalid & m_axi.axi_arready;
  assign w_r_hs  = r_rready  & m_axi.axi_rvalid;

  // A single address register serves both AW and AR since only one transaction is in flight.
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_wstrb    = r_wstrb;
    w_awvalid  = r_awvalid;
    w_wvalid   = r_wvalid;
    w_bready   = r_bready;
    w_arvalid  = r_arvalid;
    w_rready   = r_rready;
    w_rrsp_dat = r_rrsp_dat;
    w_rrsp_val = 1'b0;
    w_wrsp_val = 1'b0;
    w_rsp_err  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_ext_wr_req) begin
          w_state   = ST_WR;
          w_addr    = i_ext_addr + MEM_BASE;
          w_wdata   = i_ext_wr_dat;
          w_wstrb   = i_ext_wen;
          w_awvalid = 1'b1;
          w_wvalid  = 1'b1;
        end else if (i_ext_rd_req) begin
          w_state   = ST_RD_ADDR;
          w_addr    = i_ext_addr + MEM_BASE;
          w_arvalid = 1'b1;
        end
      end

      ST_WR: begin
        // A dropped valid doubles as the "phase done" flag for AW and W.
        if (w_aw_hs) w_awvalid = 1'b0;
        if (w_w_hs)  w_wvalid  = 1'b0;
        if (!w_awvalid && !w_wvalid) begin
          w_state  = ST_WR_RSP;
          w_bready = 1'b1;
        end
      end

      ST_WR_RSP: begin
        if (w_b_hs) begin
          w_state    = ST_IDLE;
          w_bready   = 1'b0;
          w_wrsp_val = 1'b1;
          w_rsp_err  = resp_is_err(m_axi.axi_bresp);
        end
      end

      ST_RD_ADDR: begin
        if (w_ar_hs) begin
          w_state   = ST_RD_DATA;
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
        end
      end

      ST_RD_DATA: begin
        if (w_r_hs) begin
          w_state    = ST_IDLE;
          w_rready   = 1'b0;
          w_rrsp_dat = m_axi.axi_rdata;
          w_rrsp_val = 1'b1;
          w_rsp_err  = resp_is_err(m_axi.axi_rresp);
        end
      end

      default: begin
        w_state   = ST_IDLE;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
      end
    endcase

    w_req_rdy = (w_state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rrsp_dat <= '0;
      r_rrsp_val <= 1'b0;
      r_wrsp_val <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_req_rdy  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_wstrb    <= w_wstrb;
      r_awvalid  <= w_awvalid;
      r_wvalid   <= w_wvalid;
      r_bready   <= w_bready;
      r_arvalid  <= w_arvalid;
      r_rready   <= w_rready;
      r_rrsp_dat <= w_rrsp_dat;
      r_rrsp_val <= w_rrsp_val;
      r_wrsp_val <= w_wrsp_val;
      r_rsp_err  <= w_rsp_err;
      r_req_rdy  <= w_req_rdy;
    end
  end

  assign m_axi.axi_awaddr  = r_addr;
  assign m_axi.axi_awvalid = r_awvalid;
  assign m_axi.axi_wdata   = r_wdata;
  assign m_axi.axi_wstrb   = r_wstrb;
  assign m_axi.axi_wvalid  = r_wvalid;
  assign m_axi.axi_bready  = r_bready;
  assign m_axi.axi_araddr  = r_addr;
  assign m_axi.axi_arvalid = r_arvalid;
  assign m_axi.axi_rready  = r_rready;

  assign o_ext_req_rdy  = r_req_rdy;
  assign o_ext_rrsp_dat = r_rrsp_dat;
  assign o_ext_rrsp_val = r_rrsp_val;
  assign o_ext_wrsp_val = r_wrsp_val;
  assign o_ext_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_ext_axil_mst.sv
// Directed bench for ext_axil_mst: the bench plays the AXI slave by hand, cycle by cycle,
// and checks every DUT output against hand-computed values.
module tb_ext_axil_mst;

  logic        clk;
  logic        rstN;
  logic        extRdReq;
  logic        extWrReq;
  logic [31:0] extAddr;
  logic [31:0] extWrDat;
  logic [3:0]  extWen;
  logic        extReqRdy;
  logic [31:0] extRrspDat;
  logic        extRrspVal;
  logic        extWrspVal;
  logic        extRspErr;

  int nVec  = 0;
  int nMiss = 0;
  int wrspCount = 0;
  int rrspCount = 0;
  int wrspBefore;

  ext_axil_mst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axiBus ();

  ext_axil_mst #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_BASE  (32'h1000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rstN),
    .i_ext_rd_req  (extRdReq),
    .i_ext_wr_req  (extWrReq),
    .i_ext_addr    (extAddr),
    .i_ext_wr_dat  (extWrDat),
    .i_ext_wen     (extWen),
    .o_ext_req_rdy (extReqRdy),
    .o_ext_rrsp_dat(extRrspDat),
    .o_ext_rrsp_val(extRrspVal),
    .o_ext_wrsp_val(extWrspVal),
    .o_ext_rsp_err (extRspErr),
    .m_axi         (axiBus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response pulses are counted mid-cycle so "exactly one pulse" can be checked.
  always @(negedge clk) begin
    if (extWrspVal) wrspCount++;
    if (extRrspVal) rrspCount++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMiss++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] dat, input logic [3:0] wen);
    extWrReq = wr;
    extRdReq = rd;
    extAddr  = addr;
    extWrDat = dat;
    extWen   = wen;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axiBus.axi_awready = 1'b0;
    axiBus.axi_wready  = 1'b0;
    axiBus.axi_bresp   = 2'b00;
    axiBus.axi_bvalid  = 1'b0;
    axiBus.axi_arready = 1'b0;
    axiBus.axi_rdata   = 32'h0;
    axiBus.axi_rresp   = 2'b00;
    axiBus.axi_rvalid  = 1'b0;
    tick(3);
    rstN = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_req_rdy",  {31'b0, extReqRdy},          32'h1);
    checkOutput("rst_awvalid",  {31'b0, axiBus.axi_awvalid}, 32'h0);
    checkOutput("rst_wvalid",   {31'b0, axiBus.axi_wvalid},  32'h0);
    checkOutput("rst_arvalid",  {31'b0, axiBus.axi_arvalid}, 32'h0);
    checkOutput("rst_bready",   {31'b0, axiBus.axi_bready},  32'h0);
    checkOutput("rst_rready",   {31'b0, axiBus.axi_rready},  32'h0);
    checkOutput("rst_rrsp_val", {31'b0, extRrspVal},         32'h0);
    checkOutput("rst_wrsp_val", {31'b0, extWrspVal},         32'h0);
    checkOutput("rst_err",      {31'b0, extRspErr},          32'h0);
    checkOutput("rst_rrsp_dat", extRrspDat,                  32'h0);

    $display("[TB] test 1: write with immediate slave");
    wrspBefore = wrspCount;
    applyStimulus(1'b1, 1'b0, 32'h4, 32'hDEAD_BEEF, 4'hF);
    axiBus.axi_awready = 1'b1;
    axiBus.axi_wready  = 1'b1;
    tick();
    checkOutput("t1_awvalid", {31'b0, axiBus.axi_awvalid}, 32'h1);
    checkOutput("t1_wvalid",  {31'b0, axiBus.axi_wvalid},  32'h1);
    checkOutput("t1_awaddr",  axiBus.axi_awaddr,           32'h1000_0004);
    checkOutput("t1_wdata",   axiBus.axi_wdata,            32'hDEAD_BEEF);
    checkOutput("t1_wstrb",   {28'b0, axiBus.axi_wstrb},   32'hF);
    checkOutput("t1_req_rdy", {31'b0, extReqRdy},          32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t1_awvalid_c2", {31'b0, axiBus.axi_awvalid}, 32'h0);
    checkOutput("t1_wvalid_c2",  {31'b0, axiBus.axi_wvalid},  32'h0);
    checkOutput("t1_bready_c2",  {31'b0, axiBus.axi_bready},  32'h1);
    axiBus.axi_awready = 1'b0;
    axiBus.axi_wready  = 1'b0;
    axiBus.axi_bvalid  = 1'b1;
    axiBus.axi_bresp   = OKAY_RESP();
    tick();
    checkOutput("t1_wrsp_val_c3", {31'b0, extWrspVal},         32'h1);
    checkOutput("t1_err_c3",      {31'b0, extRspErr},          32'h0);
    checkOutput("t1_req_rdy_c3",  {31'b0, extReqRdy},          32'h1);
    checkOutput("t1_bready_c3",   {31'b0, axiBus.axi_bready},  32'h0);
    axiBus.axi_bvalid = 1'b0;
    tick();
    checkOutput("t1_wrsp_val_c4", {31'b0, extWrspVal}, 32'h0);
    checkOutput("t1_wrsp_count",  wrspCount - wrspBefore, 32'h1);

    $display("[TB] test 2: read with late arready");
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 4'h0);
    tick();
    checkOutput("t2_arvalid_c1", {31'b0, axiBus.axi_arvalid}, 32'h1);
    checkOutput("t2_araddr",     axiBus.axi_araddr,           32'h1000_0008);
    checkOutput("t2_awvalid_c1", {31'b0, axiBus.axi_awvalid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t2_arvalid_c2", {31'b0, axiBus.axi_arvalid}, 32'h1);
    tick();
    checkOutput("t2_arvalid_c3", {31'b0, axiBus.axi_arvalid}, 32'h1);
    checkOutput("t2_araddr_c3",  axiBus.axi_araddr,           32'h1000_0008);
    axiBus.axi_arready = 1'b1;
    tick();
    checkOutput("t2_arvalid_c4", {31'b0, axiBus.axi_arvalid}, 32'h0);
    checkOutput("t2_rready_c4",  {31'b0, axiBus.axi_rready},  32'h1);
    axiBus.axi_arready = 1'b0;
    axiBus.axi_rvalid  = 1'b1;
    axiBus.axi_rdata   = 32'h1234_5678;
    axiBus.axi_rresp   = 2'b00;
    tick();
    checkOutput("t2_rrsp_val", {31'b0, extRrspVal},        32'h1);
    checkOutput("t2_rrsp_dat", extRrspDat,                 32'h1234_5678);
    checkOutput("t2_err",      {31'b0, extRspErr},         32'h0);
    checkOutput("t2_rready_c5",{31'b0, axiBus.axi_rready}, 32'h0);
    axiBus.axi_rvalid = 1'b0;
    tick();
    checkOutput("t2_rrsp_val_c6", {31'b0, extRrspVal}, 32'h0);

    $display("[TB] test 3a: wready before awready");
    wrspBefore = wrspCount;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'hA5A5_A5A5, 4'h3);
    tick();
    checkOutput("t3a_wstrb", {28'b0, axiBus.axi_wstrb}, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axiBus.axi_wready = 1'b1;
    tick();
    checkOutput("t3a_wvalid_c2",  {31'b0, axiBus.axi_wvalid},  32'h0);
    checkOutput("t3a_awvalid_c2", {31'b0, axiBus.axi_awvalid}, 32'h1);
    axiBus.axi_wready = 1'b0;
    tick();
    checkOutput("t3a_awvalid_c3", {31'b0, axiBus.axi_awvalid}, 32'h1);
    checkOutput("t3a_awaddr_c3",  axiBus.axi_awaddr,           32'h1000_0010);
    checkOutput("t3a_bready_c3",  {31'b0, axiBus.axi_bready},  32'h0);
    axiBus.axi_awready = 1'b1;
    tick();
    checkOutput("t3a_awvalid_c4", {31'b0, axiBus.axi_awvalid}, 32'h0);
    checkOutput("t3a_bready_c4",  {31'b0, axiBus.axi_bready},  32'h1);
    axiBus.axi_awready = 1'b0;
    axiBus.axi_bvalid  = 1'b1;
    tick();
    checkOutput("t3a_wrsp_val", {31'b0, extWrspVal}, 32'h1);
    axiBus.axi_bvalid = 1'b0;
    tick();
    checkOutput("t3a_wrsp_count", wrspCount - wrspBefore, 32'h1);

    $display("[TB] test 3b: awready before wready");
    wrspBefore = wrspCount;
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0F0F_0F0F, 4'hC);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axiBus.axi_awready = 1'b1;
    tick();
    checkOutput("t3b_awvalid_c2", {31'b0, axiBus.axi_awvalid}, 32'h0);
    checkOutput("t3b_wvalid_c2",  {31'b0, axiBus.axi_wvalid},  32'h1);
    axiBus.axi_awready = 1'b0;
    tick();
    checkOutput("t3b_wvalid_c3", {31'b0, axiBus.axi_wvalid}, 32'h1);
    checkOutput("t3b_wdata_c3",  axiBus.axi_wdata,           32'h0F0F_0F0F);
    checkOutput("t3b_wstrb_c3",  {28'b0, axiBus.axi_wstrb},  32'hC);
    axiBus.axi_wready = 1'b1;
    tick();
    checkOutput("t3b_wvalid_c4", {31'b0, axiBus.axi_wvalid}, 32'h0);
    checkOutput("t3b_bready_c4", {31'b0, axiBus.axi_bready}, 32'h1);
    axiBus.axi_wready = 1'b0;
    axiBus.axi_bvalid = 1'b1;
    tick();
    checkOutput("t3b_wrsp_val", {31'b0, extWrspVal}, 32'h1);
    axiBus.axi_bvalid = 1'b0;
    tick();
    checkOutput("t3b_wrsp_count", wrspCount - wrspBefore, 32'h1);

    $display("[TB] test 4: simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h1111_2222, 4'hF);
    tick();
    checkOutput("t4_awvalid", {31'b0, axiBus.axi_awvalid}, 32'h1);
    checkOutput("t4_arvalid", {31'b0, axiBus.axi_arvalid}, 32'h0);
    checkOutput("t4_awaddr",  axiBus.axi_awaddr,           32'h1000_0020);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axiBus.axi_awready = 1'b1;
    axiBus.axi_wready  = 1'b1;
    tick();
    checkOutput("t4_arvalid_c2", {31'b0, axiBus.axi_arvalid}, 32'h0);
    axiBus.axi_awready = 1'b0;
    axiBus.axi_wready  = 1'b0;
    axiBus.axi_bvalid  = 1'b1;
    tick();
    checkOutput("t4_wrsp_val", {31'b0, extWrspVal}, 32'h1);
    axiBus.axi_bvalid = 1'b0;
    tick();
    checkOutput("t4_arvalid_c4", {31'b0, axiBus.axi_arvalid}, 32'h0);
    checkOutput("t4_req_rdy_c4", {31'b0, extReqRdy},          32'h1);

    $display("[TB] test 5a: write with SLVERR");
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h5555_AAAA, 4'h1);
    axiBus.axi_awready = 1'b1;
    axiBus.axi_wready  = 1'b1;
    tick();
    checkOutput("t5a_awaddr", axiBus.axi_awaddr, 32'h1000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    axiBus.axi_awready = 1'b0;
    axiBus.axi_wready  = 1'b0;
    axiBus.axi_bvalid  = 1'b1;
    axiBus.axi_bresp   = 2'b10;
    tick();
    checkOutput("t5a_wrsp_val", {31'b0, extWrspVal}, 32'h1);
    checkOutput("t5a_err",      {31'b0, extRspErr},  32'h1);
    axiBus.axi_bvalid = 1'b0;
    axiBus.axi_bresp  = 2'b00;
    tick();
    checkOutput("t5a_err_after", {31'b0, extRspErr}, 32'h0);

    $display("[TB] test 5b: read with DECERR and address wrap");
    applyStimulus(1'b0, 1'b1, 32'hF000_0004, 32'h0, 4'h0);
    tick();
    checkOutput("t5b_araddr_wrap", axiBus.axi_araddr, 32'h0000_0004);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h9999_9999, 4'hF);
    axiBus.axi_arready = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axiBus.axi_arready = 1'b0;
    axiBus.axi_rvalid  = 1'b1;
    axiBus.axi_rdata   = 32'hCAFE_F00D;
    axiBus.axi_rresp   = 2'b11;
    tick();
    checkOutput("t5b_rrsp_val", {31'b0, extRrspVal}, 32'h1);
    checkOutput("t5b_err",      {31'b0, extRspErr},  32'h1);
    checkOutput("t5b_rrsp_dat", extRrspDat,          32'hCAFE_F00D);
    axiBus.axi_rvalid = 1'b0;
    axiBus.axi_rresp  = 2'b00;
    tick();
    checkOutput("t5b_err_after",     {31'b0, extRspErr},          32'h0);
    checkOutput("t5b_dat_held",      extRrspDat,                  32'hCAFE_F00D);
    checkOutput("t5b_busy_wr_ignored", {31'b0, axiBus.axi_awvalid}, 32'h0);

    $display("[TB] test 6: reset during WR_RSP");
    wrspBefore = wrspCount;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h7777_8888, 4'hF);
    axiBus.axi_awready = 1'b1;
    axiBus.axi_wready  = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t6_bready_pre", {31'b0, axiBus.axi_bready}, 32'h1);
    axiBus.axi_awready = 1'b0;
    axiBus.axi_wready  = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("t6_bready_rst",  {31'b0, axiBus.axi_bready},  32'h0);
    checkOutput("t6_awvalid_rst", {31'b0, axiBus.axi_awvalid}, 32'h0);
    checkOutput("t6_wvalid_rst",  {31'b0, axiBus.axi_wvalid},  32'h0);
    checkOutput("t6_arvalid_rst", {31'b0, axiBus.axi_arvalid}, 32'h0);
    checkOutput("t6_rready_rst",  {31'b0, axiBus.axi_rready},  32'h0);
    checkOutput("t6_wrsp_rst",    {31'b0, extWrspVal},         32'h0);
    axiBus.axi_bvalid = 1'b1;
    tick(2);
    axiBus.axi_bvalid = 1'b0;
    rstN = 1'b1;
    tick();
    checkOutput("t6_req_rdy_after", {31'b0, extReqRdy},          32'h1);
    checkOutput("t6_bready_after",  {31'b0, axiBus.axi_bready},  32'h0);
    checkOutput("t6_no_wrsp",       wrspCount - wrspBefore,      32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

  function automatic logic [1:0] OKAY_RESP();
    return 2'b00;
  endfunction

endmodule
